// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock controller: state encoding, default
// timing constants and constant-evaluation helpers.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    localparam int DEF_RST_CYC      = 16;
    localparam int DEF_STABLE_CYC   = 1024;
    localparam int DEF_LOCK_TIMEOUT = 500000;
    localparam int DEF_MAX_RETRY    = 7;
    localparam int DEF_CNT_W        = 8;

    // Retry counter is wide enough for MAX_RETRY up to 15.
    localparam int RETRY_W = 4;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, one independent chain per bit, async reset to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_q;
            logic sync_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                end else begin
                    meta_q <= d[gi];
                    sync_q <= meta_q;
                end
            end

            assign q[gi] = sync_q;
        end
    endgenerate

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL sequencer: pulses the PLL reset, qualifies a synchronized stable lock,
// releases the core reset, and retries or gives up on lock trouble.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYC      = DEF_RST_CYC,
    parameter int STABLE_CYC   = DEF_STABLE_CYC,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             ready,
    output logic             sys_rst,
    output logic             fail,
    output logic [CNT_W-1:0] relock_cnt,
    output logic [2:0]       state_o
);

    localparam int TMR_MAX = max3(RST_CYC, STABLE_CYC, LOCK_TIMEOUT);
    localparam int TMR_W   = (clog2(TMR_MAX) < 1) ? 1 : clog2(TMR_MAX);

    localparam logic [TMR_W-1:0]   RST_LAST    = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0]   STABLE_LAST = TMR_W'(STABLE_CYC - 1);
    localparam logic [TMR_W-1:0]   TO_LAST     = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    logic lock_s;

    pll_state_e         state_q, state_d;
    logic [TMR_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [RETRY_W-1:0] retry_inc;
    logic [CNT_W-1:0]   relock_cnt_q, relock_cnt_d;
    logic               pll_rst_q, pll_rst_d;
    logic               ready_q, ready_d;
    logic               sys_rst_q, sys_rst_d;
    logic               fail_q, fail_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (lock_s)
    );

    assign retry_inc = retry_q + RETRY_W'(1);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RESET_PLL;
            cnt_q        <= '0;
            retry_q      <= '0;
            relock_cnt_q <= '0;
            pll_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            sys_rst_q    <= 1'b1;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            relock_cnt_q <= relock_cnt_d;
            pll_rst_q    <= pll_rst_d;
            ready_q      <= ready_d;
            sys_rst_q    <= sys_rst_d;
            fail_q       <= fail_d;
        end
    end

    // A manual relock request overrides every state and every other event.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        relock_cnt_d = relock_cnt_q;

        if (relock_req) begin
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + TMR_W'(1);
                    end
                end

                ST_WAIT_LOCK: begin
                    // Lock arriving on the timeout cycle still counts as lock.
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        retry_d = retry_inc;
                        cnt_d   = '0;
                        state_d = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RESET_PLL;
                    end else begin
                        cnt_d = cnt_q + TMR_W'(1);
                    end
                end

                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + TMR_W'(1);
                    end
                end

                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_RESET_PLL;
                        cnt_d   = '0;
                        if (relock_cnt_q != '1) begin
                            relock_cnt_d = relock_cnt_q + CNT_W'(1);
                        end
                    end
                end

                ST_FAIL: begin
                    state_d = ST_FAIL;
                end

                default: begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered outputs
    // change on the same edge as the state register.
    always_comb begin
        pll_rst_d = 1'b0;
        ready_d   = 1'b0;
        fail_d    = 1'b0;
        case (state_d)
            ST_RESET_PLL: pll_rst_d = 1'b1;
            ST_RUN:       ready_d   = 1'b1;
            ST_FAIL:      fail_d    = 1'b1;
            default:      pll_rst_d = 1'b0;
        endcase
        sys_rst_d = !ready_d;
    end

    assign pll_rst    = pll_rst_q;
    assign ready      = ready_q;
    assign sys_rst    = sys_rst_q;
    assign fail       = fail_q;
    assign relock_cnt = relock_cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with a behavioural PLL model and a queue
// of expected values popped at each observation point.
module tb_pll_lock_ctrl;

    localparam int RST_CYC      = 4;
    localparam int STABLE_CYC   = 8;
    localparam int LOCK_TIMEOUT = 32;
    localparam int MAX_RETRY    = 3;
    localparam int CNT_W        = 8;

    logic             refclk = 1'b0;
    logic             rst = 1'b1;
    logic             locked;
    logic             relock_req = 1'b0;
    logic             pll_rst;
    logic             ready;
    logic             sys_rst;
    logic             fail;
    logic [CNT_W-1:0] relock_cnt;
    logic [2:0]       state_o;

    pll_lock_ctrl #(
        .RST_CYC      (RST_CYC),
        .STABLE_CYC   (STABLE_CYC),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY),
        .CNT_W        (CNT_W)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .locked     (locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .ready      (ready),
        .sys_rst    (sys_rst),
        .fail       (fail),
        .relock_cnt (relock_cnt),
        .state_o    (state_o)
    );

    always #10 refclk = ~refclk;

    // PLL model: locks 5 cycles after pll_rst falls when enabled.
    logic model_en = 1'b1;
    logic drop = 1'b0;
    logic model_locked = 1'b0;
    int   mcnt = 0;

    always @(posedge refclk) begin
        if (pll_rst) begin
            mcnt         <= 0;
            model_locked <= 1'b0;
        end else if (mcnt < 4) begin
            mcnt         <= mcnt + 1;
            model_locked <= 1'b0;
        end else begin
            model_locked <= model_en;
        end
    end

    assign locked = model_locked & ~drop;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    // Monitor: pll_rst pulse length, WAIT_LOCK dwell, pll_rst rises.
    int hi_run = 0;
    int last_pulse = 0;
    int wait_run = 0;
    int last_wait = 0;
    int rises = 0;
    logic pll_prev = 1'b1;

    always @(negedge refclk) begin
        #1;
        if (rst) begin
            hi_run   = 0;
            wait_run = 0;
            pll_prev = 1'b1;
        end else begin
            if (pll_rst) hi_run++;
            else begin
                if (hi_run > 0) last_pulse = hi_run;
                hi_run = 0;
            end
            if (state_o == 3'd1) wait_run++;
            else begin
                if (wait_run > 0) last_wait = wait_run;
                wait_run = 0;
            end
            if (pll_rst && !pll_prev) rises++;
            pll_prev = pll_rst;
        end
        checks++;
        assert (sys_rst === ~ready) else begin
            errors++;
            $error("FAIL sys_rst_inv: observed %0b expected %0b", sys_rst, ~ready);
        end
    end

    task automatic push(input int v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input int obs);
        int expv;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge refclk);
    endtask

    // Negedges until ready==val; -1 when the bound expires.
    task automatic wait_ready(input logic val, input int max, output int n);
        n = 0;
        while (ready !== val && n < max) begin
            @(negedge refclk);
            n++;
        end
        if (ready !== val) n = -1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, output int n);
        n = 0;
        while (state_o !== s && n < max) begin
            @(negedge refclk);
            n++;
        end
        if (state_o !== s) n = -1;
    endtask

    task automatic wait_not_state(input logic [2:0] s, input int max, output int n);
        n = 0;
        while (state_o === s && n < max) begin
            @(negedge refclk);
            n++;
        end
        if (state_o === s) n = -1;
    endtask

    task automatic pulse_relock();
        relock_req = 1'b1;
        cyc(1);
        relock_req = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r0;
        int st;

        // Reset values
        cyc(3);
        push(1); chk("rst_pll_rst", pll_rst);
        push(0); chk("rst_ready", ready);
        push(1); chk("rst_sys_rst", sys_rst);
        push(0); chk("rst_fail", fail);
        push(0); chk("rst_relock_cnt", relock_cnt);
        push(0); chk("rst_state", state_o);

        // 1: normal start-up
        rst = 1'b0;
        wait_state(3'd1, 20, n);
        push(1); chk("s1_reach_wait", n >= 0);
        cyc(1);
        push(RST_CYC); chk("s1_pll_rst_len", last_pulse);
        n = 0;
        while (!locked && n < 40) begin cyc(1); n++; end
        push(1); chk("s1_locked_seen", locked);
        // 2 sync flops + entry into STABLE + STABLE_CYC cycles in STABLE
        wait_ready(1'b1, 100, n);
        push(3 + STABLE_CYC); chk("s1_lock_to_ready", n);
        push(0); chk("s1_fail", fail);
        push(0); chk("s1_relock_cnt", relock_cnt);
        push(3); chk("s1_state_run", state_o);

        // 2: lock loss in RUN
        drop = 1'b1;
        wait_ready(1'b0, 10, n);
        push(3); chk("s2_loss_to_notready", n);
        drop = 1'b0;
        push(1); chk("s2_relock_cnt", relock_cnt);
        wait_state(3'd1, 20, n);
        cyc(1);
        push(RST_CYC); chk("s2_pll_rst_len", last_pulse);
        wait_ready(1'b1, 100, n);
        push(1); chk("s2_ready_back", n >= 0);

        // 3: PLL never locks
        model_en = 1'b0;
        drop = 1'b1;
        wait_ready(1'b0, 10, n);
        drop = 1'b0;
        push(2); chk("s3_relock_cnt", relock_cnt);
        for (int a = 0; a < MAX_RETRY; a++) begin
            wait_state(3'd1, 20, n);
            push(1); chk("s3_reach_wait", n >= 0);
            wait_not_state(3'd1, 100, n);
            st = state_o;
            cyc(1);
            push(RST_CYC); chk("s3_pll_rst_len", last_pulse);
            push(LOCK_TIMEOUT); chk("s3_wait_len", last_wait);
            push((a == MAX_RETRY - 1) ? 4 : 0); chk("s3_state_after_to", st);
        end
        r0 = rises;
        cyc(10);
        push(1); chk("s3_fail", fail);
        push(0); chk("s3_pll_rst", pll_rst);
        push(1); chk("s3_sys_rst", sys_rst);
        push(4); chk("s3_state_fail", state_o);
        push(r0); chk("s3_no_more_pulses", rises);

        // 4: recover from FAIL with relock_req
        model_en = 1'b1;
        pulse_relock();
        push(0); chk("s4_fail_cleared", fail);
        push(0); chk("s4_state_reset", state_o);
        wait_ready(1'b1, 100, n);
        push(1); chk("s4_ready", n >= 0);
        push(2); chk("s4_relock_cnt", relock_cnt);

        // 5: glitch during STABLE restarts the stable count
        pulse_relock();
        push(2); chk("s5_relock_unchanged", relock_cnt);
        wait_state(3'd2, 50, n);
        push(1); chk("s5_reach_stable", n >= 0);
        cyc(2);
        r0 = rises;
        drop = 1'b1;
        cyc(2);
        drop = 1'b0;
        cyc(1);
        push(1); chk("s5_back_to_wait", state_o);
        // one more low lock_s cycle, then entry into STABLE + STABLE_CYC
        wait_ready(1'b1, 100, n);
        push(2 + STABLE_CYC); chk("s5_relock_to_ready", n);
        push(r0); chk("s5_no_retry_pulse", rises);

        // relock_req coinciding with lock loss in RUN
        drop = 1'b1;
        cyc(2);
        relock_req = 1'b1;
        cyc(1);
        relock_req = 1'b0;
        drop = 1'b0;
        push(0); chk("s6_coinc_state", state_o);
        push(2); chk("s6_coinc_relock_cnt", relock_cnt);
        wait_ready(1'b1, 100, n);
        push(1); chk("s6_coinc_ready", n >= 0);

        // 6: asynchronous reset during WAIT_LOCK
        model_en = 1'b0;
        pulse_relock();
        wait_state(3'd1, 20, n);
        cyc(5);
        #5 rst = 1'b1;
        #1;
        push(0); chk("s6_arst_state", state_o);
        push(1); chk("s6_arst_pll_rst", pll_rst);
        push(0); chk("s6_arst_ready", ready);
        push(1); chk("s6_arst_sys_rst", sys_rst);
        push(0); chk("s6_arst_fail", fail);
        push(0); chk("s6_arst_relock_cnt", relock_cnt);
        @(negedge refclk);
        rst = 1'b0;
        model_en = 1'b1;

        // relock_cnt saturation
        for (int i = 0; i < 257; i++) begin
            wait_ready(1'b1, 200, n);
            if (n < 0) begin
                push(1); chk("s6_sat_ready_timeout", 0);
                break;
            end
            drop = 1'b1;
            wait_ready(1'b0, 10, n);
            drop = 1'b0;
            if (i == 253) begin
                push(254); chk("s6_relock_cnt_254", relock_cnt);
            end
        end
        push(255); chk("s6_relock_cnt_sat", relock_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
